mat_mul_seq: RTL and testbench
==============================

Name: mat_mul_seq

Overview:
- Sequential signed matrix multiplier: C[M][L] = A[M][N] x B[N][L], one multiply-accumulate (MAC) per clock.
- Parametrised successor of the team's fixed matmul block. Adds:
  - explicit start/busy/done handshake;
  - operand capture on start;
  - a full-precision accumulator;
  - a separate result width.
- Sits between the operand register file and the result writeback stage of the compute datapath.

Parameters:
- M, 2, rows of A and of C; must be >= 1.
- N, 2, columns of A and rows of B (the shared dimension); must be >= 1.
- L, 2, columns of B and of C; must be >= 1.
- WIDTH, 8, bit width of each A/B element, two's complement.
- RES_WIDTH, 2*WIDTH+$clog2(N+1), bit width of each C element.
- Zero dimensions or WIDTH < 2 are rejected at elaboration with $error. No runtime invalid flag.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- start  in  1  request; sampled only while busy=0.
- mat_a  in  M*N*WIDTH  A, row-major; element (r,c) at [(r*N+c)*WIDTH +: WIDTH].
- mat_b  in  N*L*WIDTH  B, row-major; element (r,c) at [(r*L+c)*WIDTH +: WIDTH].
- result  out  M*L*RES_WIDTH  C, row-major; element (r,c) at [(r*L+c)*RES_WIDTH +: RES_WIDTH].
- busy  out  1  high while a computation is in progress.
- done  out  1  single-cycle pulse when result is updated.

Behaviour:
- Reset values: result=0, busy=0, done=0, state=IDLE, all indices and the accumulator cleared.
- States:
  - IDLE -> RUN on start.
  - RUN -> DONE after the final MAC.
  - DONE -> IDLE unconditionally.
  - start is also accepted in DONE, which then moves to RUN.
- Start acceptance (edge t0, start=1, busy=0):
  - mat_a and mat_b are copied into internal operand registers.
  - busy=1 from t0; the accumulator and indices i, j, k are cleared.
  - Later input changes do not affect the running computation.
- RUN: edges t0+1 through t0+M*N*L each perform acc += A[i][k]*B[k][j].
  - k is the innermost index, then j, then i.
  - When k wraps from N-1, the finished acc is written to internal C slot (i,j) and acc is cleared.
- Final MAC edge (t0+M*N*L): the whole internal C is transferred to result, state=DONE.
  - From that edge: done=1 for exactly one cycle, busy=0.
  - Latency from the start edge to done high is M*N*L cycles. A 1x1x1 multiply gives done on the edge after start.
- result holds its value until the next computation completes. It is never partially updated.
- start while busy=1 is ignored: no queueing, no error.
- Arithmetic:
  - Products are the full 2*WIDTH signed result.
  - The accumulator is 2*WIDTH+$clog2(N+1) bits and never overflows.
  - Narrowing to RES_WIDTH is defined under Optional Feature. If RES_WIDTH >= accumulator width, the value is sign-extended.
- Reset asserted mid-RUN: aborts immediately and asynchronously. All outputs return to reset values, including result=0. No done pulse is produced.

Optional Feature:
- Macro: MAT_MUL_SEQ_SAT_EN.
- Without it: narrowing keeps the low RES_WIDTH bits (two's-complement wrap).
- With it: each C element is clamped to [-2^(RES_WIDTH-1), 2^(RES_WIDTH-1)-1] before transfer to result.
- Ports and timing are identical in both builds.

Decomposition:
- Package mat_mul_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - function acc_width(width, n) returning 2*width+$clog2(n+1);
  - function narrow(value, res_width), containing the saturate/wrap selection under the macro.
- One sub-module, mat_mul_mac:
  - signed WIDTH x WIDTH multiplier feeding the accumulator register;
  - inputs: clear, en, a, b; output: acc.
- The top level owns the FSM, index counters, operand capture and result register.

Test Plan:
- Basic 2x2x2 (WIDTH=8, default RES_WIDTH): A=[[1,2],[3,4]], B=[[5,6],[7,8]], start one cycle -> done exactly 8 cycles after start edge, result=[[19,22],[43,50]], busy high for those 8 cycles.
- Signed, non-square M=1, N=3, L=2: A=[[-1,2,-3]], B=[[4,-5],[6,7],[-8,9]] -> result=[[32,-8]], done after 6 cycles.
- Narrowing M=1, N=2, L=1, WIDTH=8, RES_WIDTH=8: A=[[127,127]], B=[[127],[127]] -> result=2 without MAT_MUL_SEQ_SAT_EN; result=127 with it.
- Handshake: start held high throughout and mat_a changed mid-run -> change ignored, one done per accepted start, next run begins on the done cycle. A start pulse during busy produces no extra done.
- Reset mid-run: assert reset at cycle 3 of a 2x2x2 run -> busy=0, done=0, result=0 immediately. A new start then yields the correct result after 8 cycles.

Source files
------------

// File: rtl/mat_mul_pkg.sv
// Shared state type and arithmetic helpers for mat_mul_seq.
// MAT_MUL_SEQ_SAT_EN selects saturating result narrowing; otherwise results wrap.
package mat_mul_pkg;

  localparam int unsigned NARROW_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Full-precision accumulator width for an n-term dot product of width-bit operands.
  function automatic int unsigned acc_width(input int unsigned width, input int unsigned n);
    return 2 * width + $clog2(n + 1);
  endfunction

  // Narrow a sign-extended value to res_width bits; caller keeps the low res_width bits.
  function automatic logic signed [NARROW_W-1:0] narrow(input logic signed [NARROW_W-1:0] value,
                                                        input int unsigned res_width);
`ifdef MAT_MUL_SEQ_SAT_EN
    logic signed [NARROW_W-1:0] hi;
    logic signed [NARROW_W-1:0] lo;
    if (res_width >= NARROW_W) return value;
    hi = (64'sd1 <<< (res_width - 1)) - 64'sd1;
    lo = ~hi;
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
`else
    if (res_width >= NARROW_W) return value;
    return (value <<< (NARROW_W - res_width)) >>> (NARROW_W - res_width);
`endif
  endfunction

endpackage

// File: rtl/mat_mul_mac.sv
// Signed multiply-accumulate: acc_c is the running sum including this cycle's product.
module mat_mul_mac #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ACC_W = 18
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    en,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [ACC_W-1:0] acc_c
);

  localparam int unsigned PROD_W = 2 * WIDTH;

  logic signed [PROD_W-1:0] prod_c;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  acc_d;

  // Clear wins over enable so a finished dot product restarts from zero.
  always_comb begin
    prod_c = PROD_W'(a) * PROD_W'(b);
    acc_c  = acc_q + ACC_W'(prod_c);
    acc_d  = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_c;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/mat_mul_seq.sv
// Sequential signed matrix multiplier C = A x B, one MAC per clock, start/busy/done handshake.
// Define MAT_MUL_SEQ_SAT_EN to saturate (instead of wrap) each C element to RES_WIDTH bits.
module mat_mul_seq
  import mat_mul_pkg::*;
#(
  parameter int unsigned M         = 2,
  parameter int unsigned N         = 2,
  parameter int unsigned L         = 2,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned RES_WIDTH = acc_width(WIDTH, N)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [M*N*WIDTH-1:0]     mat_a,
  input  logic [N*L*WIDTH-1:0]     mat_b,
  output logic [M*L*RES_WIDTH-1:0] result,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned ACC_W    = acc_width(WIDTH, N);
  localparam int unsigned IW       = (M > 1) ? $clog2(M) : 1;
  localparam int unsigned KW       = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned JW       = (L > 1) ? $clog2(L) : 1;
  localparam int unsigned RES_BITS = M * L * RES_WIDTH;
  localparam logic [IW-1:0] I_LAST = IW'(M - 1);
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);
  localparam logic [JW-1:0] J_LAST = JW'(L - 1);

  if (M == 0 || N == 0 || L == 0 || WIDTH < 2) begin : g_bad_dims
    $error("mat_mul_seq: M, N, L must be >= 1 and WIDTH >= 2");
  end
  if (RES_WIDTH == 0 || RES_WIDTH > NARROW_W || ACC_W > NARROW_W) begin : g_bad_width
    $error("mat_mul_seq: RES_WIDTH and accumulator width must be 1..64");
  end

  typedef logic signed [WIDTH-1:0] elem_t;
  typedef logic signed [ACC_W-1:0] acc_t;

  state_e        state_q, state_d;
  elem_t         a_q [M][N], a_d [M][N], a_in_c [M][N];
  elem_t         b_q [N][L], b_d [N][L], b_in_c [N][L];
  acc_t          c_q [M][L], c_d [M][L];
  logic [IW-1:0] i_q, i_d;
  logic [JW-1:0] j_q, j_d;
  logic [KW-1:0] k_q, k_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [RES_BITS-1:0] result_q, result_d, res_narrow_c;
  logic          accept_c, mac_clear_c, mac_en_c, slot_wr_c, final_c;
  acc_t          acc_c;

  // Unpack the flat row-major operand buses.
  for (genvar r = 0; r < M; r++) begin : g_a_row
    for (genvar c = 0; c < N; c++) begin : g_a_col
      assign a_in_c[r][c] = mat_a[(r*N + c)*WIDTH +: WIDTH];
    end
  end
  for (genvar r = 0; r < N; r++) begin : g_b_row
    for (genvar c = 0; c < L; c++) begin : g_b_col
      assign b_in_c[r][c] = mat_b[(r*L + c)*WIDTH +: WIDTH];
    end
  end

  mat_mul_mac #(
    .WIDTH (WIDTH),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk   (clk),
    .reset (reset),
    .clear (mac_clear_c),
    .en    (mac_en_c),
    .a     (a_q[i_q][k_q]),
    .b     (b_q[k_q][j_q]),
    .acc_c (acc_c)
  );

  // Next state and index walk: k innermost, then j, then i.
  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    j_d         = j_q;
    k_d         = k_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    accept_c    = 1'b0;
    mac_clear_c = 1'b0;
    mac_en_c    = 1'b0;
    slot_wr_c   = 1'b0;
    final_c     = 1'b0;
    case (state_q)
      IDLE: accept_c = start;
      RUN: begin
        mac_en_c = 1'b1;
        k_d      = k_q + KW'(1);
        if (k_q == K_LAST) begin
          k_d         = '0;
          mac_clear_c = 1'b1;
          slot_wr_c   = 1'b1;
          j_d         = j_q + JW'(1);
          if (j_q == J_LAST) begin
            j_d = '0;
            i_d = i_q + IW'(1);
            if (i_q == I_LAST) begin
              i_d     = '0;
              final_c = 1'b1;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              state_d = DONE;
            end
          end
        end
      end
      DONE: begin
        state_d  = IDLE;
        accept_c = start;
      end
      default: state_d = IDLE;
    endcase
    if (accept_c) begin
      state_d     = RUN;
      busy_d      = 1'b1;
      mac_clear_c = 1'b1;
      i_d         = '0;
      j_d         = '0;
      k_d         = '0;
    end
  end

  // Operand capture on accepted start only.
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    if (accept_c) begin
      a_d = a_in_c;
      b_d = b_in_c;
    end
  end

  // Internal C slot gets the finished dot product as k wraps.
  always_comb begin
    c_d = c_q;
    if (slot_wr_c) begin
      c_d[i_q][j_q] = acc_c;
    end
  end

  for (genvar r = 0; r < M; r++) begin : g_res_row
    for (genvar c = 0; c < L; c++) begin : g_res_col
      assign res_narrow_c[(r*L + c)*RES_WIDTH +: RES_WIDTH] =
        RES_WIDTH'(narrow(NARROW_W'(c_d[r][c]), RES_WIDTH));
    end
  end

  // Result is replaced as a whole, only on the final MAC.
  always_comb begin
    result_d = result_q;
    if (final_c) begin
      result_d = res_narrow_c;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '{default: '0};
      b_q      <= '{default: '0};
      c_q      <= '{default: '0};
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_mat_mul_seq.sv
// Self-checking bench for mat_mul_seq: three configurations against a plain-arithmetic reference.
// Honours MAT_MUL_SEQ_SAT_EN for the expected narrowing behaviour.
module tb_mat_mul_seq;

  localparam int DM [3] = '{2, 1, 1};
  localparam int DN [3] = '{2, 3, 2};
  localparam int DL [3] = '{2, 2, 1};
  localparam int RW [3] = '{18, 18, 8};
`ifdef MAT_MUL_SEQ_SAT_EN
  localparam logic [7:0] NARROW_EXP = 8'd127;
`else
  localparam logic [7:0] NARROW_EXP = 8'd2;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  st;
  logic [2:0]  bz;
  logic [2:0]  dn;
  logic [31:0] a0, b0;
  logic [23:0] a1;
  logic [47:0] b1;
  logic [15:0] a2, b2;
  logic [71:0] r0;
  logic [35:0] r1;
  logic [7:0]  r2;

  int checks   = 0;
  int failures = 0;
  int ca [3][3];
  int cb [3][3];

  always #5 clk = ~clk;

  mat_mul_seq #(.M(2), .N(2), .L(2), .WIDTH(8)) u0 (
    .clk(clk), .reset(reset), .start(st[0]), .mat_a(a0), .mat_b(b0),
    .result(r0), .busy(bz[0]), .done(dn[0]));
  mat_mul_seq #(.M(1), .N(3), .L(2), .WIDTH(8)) u1 (
    .clk(clk), .reset(reset), .start(st[1]), .mat_a(a1), .mat_b(b1),
    .result(r1), .busy(bz[1]), .done(dn[1]));
  mat_mul_seq #(.M(1), .N(2), .L(1), .WIDTH(8), .RES_WIDTH(8)) u2 (
    .clk(clk), .reset(reset), .start(st[2]), .mat_a(a2), .mat_b(b2),
    .result(r2), .busy(bz[2]), .done(dn[2]));

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [127:0] res_of(input int u);
    case (u)
      0:       return 128'(r0);
      1:       return 128'(r1);
      default: return 128'(r2);
    endcase
  endfunction

  function automatic logic [127:0] pack_mat(input int m [3][3], input int rows, input int cols);
    logic [127:0] p;
    p = '0;
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < cols; c++)
        for (int bt = 0; bt < 8; bt++)
          p[(r*cols + c)*8 + bt] = m[r][c][bt];
    return p;
  endfunction

  // Reference: textbook dot products, optional clamp, then keep the low result bits.
  function automatic logic [127:0] model(input int u, input int a [3][3], input int b [3][3]);
    logic [127:0] p;
    longint s;
    longint lim;
    p = '0;
    for (int r = 0; r < DM[u]; r++) begin
      for (int c = 0; c < DL[u]; c++) begin
        s = 0;
        for (int k = 0; k < DN[u]; k++) s += longint'(a[r][k]) * longint'(b[k][c]);
        lim = longint'(1) << (RW[u] - 1);
`ifdef MAT_MUL_SEQ_SAT_EN
        if (s > lim - 1) s = lim - 1;
        if (s < -lim) s = -lim;
`endif
        for (int bt = 0; bt < RW[u]; bt++) p[(r*DL[u] + c)*RW[u] + bt] = s[bt];
      end
    end
    return p;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int u);
    logic [127:0] pa;
    logic [127:0] pb;
    pa = pack_mat(ca, DM[u], DN[u]);
    pb = pack_mat(cb, DN[u], DL[u]);
    case (u)
      0: begin a0 = pa[31:0]; b0 = pb[31:0]; end
      1: begin a1 = pa[23:0]; b1 = pb[47:0]; end
      default: begin a2 = pa[15:0]; b2 = pb[15:0]; end
    endcase
  endtask

  task automatic rand_ops();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        ca[r][c] = int'($urandom_range(255)) - 128;
        cb[r][c] = int'($urandom_range(255)) - 128;
      end
  endtask

  // Counts edges after the start edge until done is seen, bounded.
  task automatic wait_done(input int u, output int n, output bit busy_ok);
    n = 0;
    busy_ok = 1'b1;
    while (dn[u] !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
      if (dn[u] !== 1'b1 && bz[u] !== 1'b1) busy_ok = 1'b0;
    end
  endtask

  task automatic run(input int u, input string tag);
    logic [127:0] exp;
    int n;
    bit busy_ok;
    exp = model(u, ca, cb);
    @(negedge clk);
    drive(u);
    st[u] = 1'b1;
    @(negedge clk);
    st[u] = 1'b0;
    check({tag, "_busy_start"}, 128'(bz[u]), 128'(1));
    wait_done(u, n, busy_ok);
    check({tag, "_latency"}, 128'(n), 128'(DM[u]*DN[u]*DL[u]));
    check({tag, "_busy_held"}, 128'(busy_ok), 128'(1));
    check({tag, "_busy_at_done"}, 128'(bz[u]), 128'(0));
    check({tag, "_result"}, res_of(u), exp);
    @(negedge clk);
    check({tag, "_done_pulse"}, 128'(dn[u]), 128'(0));
    check({tag, "_result_held"}, res_of(u), exp);
  endtask

  initial begin
    logic [127:0] exp1;
    logic [127:0] exp2;
    logic [127:0] got;
    int n;
    int cnt;
    bit ok;

    reset = 1'b1;
    st = '0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0; a2 = '0; b2 = '0;
    repeat (2) @(negedge clk);
    check("reset_u0", {56'(0), r0, bz[0], dn[0]}, '0);
    check("reset_u1", {92'(0), r1, bz[1], dn[1]}, '0);
    check("reset_u2", {120'(0), r2, bz[2], dn[2]}, '0);
    reset = 1'b0;

    // Basic 2x2x2
    ca[0][0] = 1; ca[0][1] = 2; ca[1][0] = 3; ca[1][1] = 4;
    cb[0][0] = 5; cb[0][1] = 6; cb[1][0] = 7; cb[1][1] = 8;
    run(0, "basic");
    check("basic_c00", 128'(r0[17:0]), 128'(18'd19));
    check("basic_c11", 128'(r0[71:54]), 128'(18'd50));

    // Signed non-square 1x3x2
    ca[0][0] = -1; ca[0][1] = 2; ca[0][2] = -3;
    cb[0][0] = 4;  cb[0][1] = -5;
    cb[1][0] = 6;  cb[1][1] = 7;
    cb[2][0] = -8; cb[2][1] = 9;
    run(1, "signed");
    check("signed_c00", 128'(r1[17:0]), 128'(18'd32));
    check("signed_c01", 128'(r1[35:18]), 128'(18'h3fff8));

    // Narrowing to 8 bits
    ca[0][0] = 127; ca[0][1] = 127; cb[0][0] = 127; cb[1][0] = 127;
    run(2, "narrow");
    check("narrow_value", 128'(r2), 128'(NARROW_EXP));

    // Most negative operands everywhere
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin ca[r][c] = -128; cb[r][c] = -128; end
    run(0, "minval");
    run(2, "minval_narrow");

    for (int t = 0; t < 8; t++) begin rand_ops(); run(0, "rand_u0"); end
    for (int t = 0; t < 4; t++) begin rand_ops(); run(1, "rand_u1"); end
    for (int t = 0; t < 4; t++) begin rand_ops(); run(2, "rand_u2"); end

    // Start held high with mat_a changed mid-run; rerun starts on the done cycle
    rand_ops();
    exp1 = model(0, ca, cb);
    @(negedge clk);
    drive(0);
    st[0] = 1'b1;
    @(negedge clk);
    repeat (3) @(negedge clk);
    for (int c = 0; c < 3; c++) ca[0][c] = ca[0][c] ^ 8'h55;
    drive(0);
    exp2 = model(0, ca, cb);
    wait_done(0, n, ok);
    check("held_latency", 128'(n + 3), 128'(8));
    check("held_result1", res_of(0), exp1);
    @(negedge clk);
    check("held_rerun_busy", 128'({bz[0], dn[0]}), 128'(2'b10));
    wait_done(0, n, ok);
    check("held_latency2", 128'(n), 128'(8));
    check("held_result2", res_of(0), exp2);
    st[0] = 1'b0;
    @(negedge clk);
    check("held_release_idle", 128'({bz[0], dn[0]}), 128'(0));
    @(negedge clk);
    check("held_no_third_run", 128'({bz[0], dn[0]}), 128'(0));

    // Start pulse while busy is ignored
    rand_ops();
    exp1 = model(0, ca, cb);
    @(negedge clk);
    drive(0);
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    repeat (3) @(negedge clk);
    rand_ops();
    drive(0);
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    cnt = 0;
    got = '0;
    repeat (20) begin
      @(negedge clk);
      if (dn[0] === 1'b1) begin
        cnt++;
        if (cnt == 1) got = res_of(0);
      end
    end
    check("busy_start_one_done", 128'(cnt), 128'(1));
    check("busy_start_result", got, exp1);

    // Asynchronous reset in the middle of a run
    rand_ops();
    @(negedge clk);
    drive(0);
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_busy", 128'(bz[0]), 128'(0));
    check("abort_done", 128'(dn[0]), 128'(0));
    check("abort_result", res_of(0), '0);
    @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (dn[0] === 1'b1) cnt++;
    end
    check("abort_no_done", 128'(cnt), 128'(0));
    rand_ops();
    run(0, "after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
